// File: rtl/button_press_classifier.sv
// Push-button front end: synchronise, debounce, then classify each
// debounced press as short (1) or long (2) with a one-cycle event.
module button_press_classifier #(
  parameter int DEBOUNCE = 2,
  parameter int LONG     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic [1:0] buttonState,
  output logic       btn_level
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HW = $clog2(LONG);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    WAIT_REL
  } state_t;

  logic          s1_q;
  logic          s2_q;
  logic [DW-1:0] db_cnt_q;
  logic [HW-1:0] hold_q;
  state_t        state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Count resets whenever the synced level agrees with the accepted one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_level <= 1'b0;
      db_cnt_q  <= '0;
    end else if (s2_q != btn_level) begin
      if (db_cnt_q == DB_MAX) begin
        btn_level <= s2_q;
        db_cnt_q  <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      buttonState <= 2'd0;
    end else begin
      buttonState <= 2'd0;
      unique case (state_q)
        IDLE: begin
          if (btn_level) begin
            state_q <= HELD;
            hold_q  <= HOLD_ONE;
          end
        end
        HELD: begin
          if (!btn_level) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            buttonState <= 2'd1;
          end else if (hold_q == HOLD_MAX) begin
            state_q     <= WAIT_REL;
            buttonState <= 2'd2;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!btn_level) begin
            state_q <= IDLE;
            hold_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          hold_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench: each press pushes its expected event and edge,
// a negedge monitor pops and compares every nonzero buttonState.
module tb_button_press_classifier;

  localparam int D = 2;
  localparam int L = 10;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic [1:0] buttonState;
  logic       btn_level;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   total;
  int   bad;
  int   n_short;
  int   n_long;

  button_press_classifier #(
    .DEBOUNCE(D),
    .LONG    (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .buttonState(buttonState),
    .btn_level  (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (buttonState !== 2'd0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got=%0d required=none",
                 cyc, buttonState);
      end else begin
        e = sb.pop_front();
        if (buttonState === 2'd1) n_short++;
        if (buttonState === 2'd2) n_long++;
        if (buttonState !== e.val || cyc != e.cyc) begin
          bad++;
          $display("FAIL event got=%0d@%0d required=%0d@%0d",
                   buttonState, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [1:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic press(input int h, input int l);
    int t;
    btn_raw = 1'b1;
    t = cyc + 1;
    if (h >= L) push(t + D + L + 1, 2'd2);
    else if (h >= D) push(t + h + D + 2, 2'd1);
    repeat (h) @(negedge clk);
    btn_raw = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d required=0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset;
    int t;
    reset   = 1'b0;
    btn_raw = 1'b1;
    repeat (10) begin
      @(negedge clk);
      total++;
      if (buttonState !== 2'd0 || btn_level !== 1'b0) begin
        bad++;
        $display("FAIL reset_state got=%0d/%0d required=0/0",
                 buttonState, btn_level);
      end
    end
    reset = 1'b1;
    t = cyc + 1;
    push(t + 13, 2'd2);
    idle(20);
    btn_raw = 1'b0;
    idle(10);
    drained("reset_held_press");
  endtask

  task automatic glitch_watch(input int n);
    repeat (n) begin
      @(negedge clk);
      total++;
      if (btn_level !== 1'b0) begin
        bad++;
        $display("FAIL glitch_level got=%0d required=0", btn_level);
      end
    end
  endtask

  task automatic test_glitch;
    btn_raw = 1'b1;
    glitch_watch(1);
    btn_raw = 1'b0;
    glitch_watch(8);
    repeat (3) begin
      btn_raw = 1'b1;
      glitch_watch(1);
      btn_raw = 1'b0;
      glitch_watch(3);
    end
    glitch_watch(6);
    drained("glitch");
  endtask

  task automatic test_short;
    press(5, 8);
    press(D, 8);
    press(L - 1, 10);
    drained("short");
  endtask

  task automatic test_long;
    press(L, 10);
    press(L + 7, 10);
    drained("long");
  endtask

  task automatic test_back_to_back;
    press(5, D);
    press(5, D);
    press(L, D);
    press(5, 8);
    drained("back_to_back");
  endtask

  task automatic test_reset_mid;
    btn_raw = 1'b1;
    idle(8);
    reset = 1'b0;
    idle(22);
    btn_raw = 1'b0;
    idle(5);
    total++;
    if (btn_level !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_level got=%0d required=0", btn_level);
    end
    reset = 1'b1;
    idle(5);
    drained("reset_mid");
    press(5, 8);
    drained("after_reset_mid");
  endtask

  task automatic test_sequence;
    n_short = 0;
    n_long  = 0;
    press(L + 5, 8);
    repeat (59) press(5, 5);
    press(L + 5, 8);
    repeat (23) press(5, 5);
    press(L + 5, 8);
    idle(10);
    drained("sequence");
    total++;
    if (n_short != 82 || n_long != 3) begin
      bad++;
      $display("FAIL sequence_counts got=%0d/%0d required=82/3",
               n_short, n_long);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    n_short = 0;
    n_long  = 0;
    reset   = 1'b0;
    btn_raw = 1'b0;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    test_sequence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 2, meaning the number of consecutive cycles of the raw level needed to accept a change (legal range 1..255).
REQ-002 SHALL have parameter LONG, default 10, meaning the number of debounced-high cycles that classify a press as long (legal range 2..65535; 10 = 1 s at 10 Hz).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-005 SHALL have port btn_raw, input, 1 bit: asynchronous, bouncing push-button level, 1 = pressed.
REQ-006 SHALL have port buttonState, output, 2 bits: registered press event to the TimeCounter; 0 = none, 1 = short press, 2 = long press; 3 is never driven.
REQ-007 SHALL have port btn_level, output, 1 bit: registered debounced button level.

Function
REQ-008 SHALL pass btn_raw through a 2-flop synchronizer (s1, s2) before any other use.
REQ-009 SHALL run a debounce counter: on each edge where s2 != btn_level, if the count equals DEBOUNCE-1 then btn_level <= s2 and count <= 0, else count increments; on each edge where s2 == btn_level, count <= 0.
REQ-010 SHALL size the counters as ceil(log2) of their parameter and SHALL NOT let them wrap.
REQ-011 SHALL implement the FSM states IDLE, HELD and WAIT_REL.
REQ-012 IDLE: when btn_level = 1, the FSM SHALL go to HELD with hold_cnt <= 1.
REQ-013 HELD, btn_level = 1, hold_cnt == LONG-1: the FSM SHALL go to WAIT_REL and set buttonState <= 2.
REQ-014 HELD, btn_level = 1, hold_cnt < LONG-1: the FSM SHALL increment hold_cnt.
REQ-015 HELD, btn_level = 0: the FSM SHALL go to IDLE and set buttonState <= 1.
REQ-016 WAIT_REL: the FSM SHALL stay until btn_level = 0, then go to IDLE with no event.
REQ-017 buttonState SHALL be nonzero for exactly one cycle per event and SHALL be 0 on every other cycle.
REQ-018 SHALL produce at most one event per debounced press: a long press emits no short event on release.
REQ-019 Raw pulse shorter than DEBOUNCE cycles: no btn_level change and no event.
REQ-020 Raw high for H cycles with DEBOUNCE <= H < LONG: exactly one event 1, asserted on the edge t+H+DEBOUNCE+2, where edge t is the first edge sampling raw high.
REQ-021 Raw high for H >= LONG cycles: exactly one event 2, asserted on the edge t+DEBOUNCE+LONG+1, while the button is still held.
REQ-022 Release and re-press in IDLE on the same edge SHALL behave as a fresh press, with no merging of presses.

Reset
REQ-023 While reset = 0 on an edge: s1, s2, btn_level, the debounce count and hold_cnt SHALL be 0, the FSM SHALL be IDLE and buttonState SHALL be 0.
REQ-024 Reset asserted mid-press (HELD or WAIT_REL) SHALL discard the press and emit no event.
REQ-025 A button already held when reset deasserts SHALL be treated as a new press after normal debounce.

Verification (DEBOUNCE=2, LONG=10, 10 Hz clk)
REQ-026 Reset low 10 cycles with btn_raw=1, then high -> buttonState=0 during reset; single 2 pulse 13 edges after the first sampling edge post-reset.
REQ-027 btn_raw 1-cycle glitch; separately 3 isolated 1-cycle glitches -> btn_level stays 0 and buttonState stays 0 throughout.
REQ-028 btn_raw high 5 cycles -> one buttonState=1 pulse, 9 edges after the first high sample; no 2 pulse.
REQ-029 btn_raw high 9 vs 10 cycles -> 9 gives a single 1 pulse; 10 gives a single 2 pulse at edge +13; neither gives a pulse on release.
REQ-030 btn_raw high 30 cycles with reset pulsed low at cycle 8 -> no event from that press; a next 5-cycle press gives a normal 1 pulse.
REQ-031 Sequence: long press, 59 short presses (5 high/5 low), long press, 23 shorts, long press -> event stream of 2, 59x1, 2, 23x1, 2; a TimeCounter connected to buttonState reaches 23:59 and returns to count mode.
